// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks EX/MEM/WB destination state behind ID and derives
// per-operand bypass selects, load-use stalls and NZCV forwarding.
module forward_scoreboard #(
  parameter int REG_W    = 5,
  parameter int NUM_SRC  = 3,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   issue_valid,
  input  logic [REG_W-1:0]                       issue_rd,
  input  logic                                   issue_regwrite,
  input  logic                                   issue_memread,
  input  logic                                   issue_setflag,
  input  logic                                   issue_flaguse,
  input  logic [NUM_SRC*REG_W-1:0]               src_addr,
  input  logic [NUM_SRC-1:0]                     src_valid,
  input  logic                                   stall_ext,
  input  logic                                   flush,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]     fwd_sel,
  output logic                                   load_use_stall,
  output logic                                   flag_fwd,
  output logic [CNT_W-1:0]                       stall_count
);

  localparam int SEL_W = $clog2(DEPTH+1);
  localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(ZERO_REG);

  logic             valid_r    [1:DEPTH];
  logic [REG_W-1:0] rd_r       [1:DEPTH];
  logic             regwrite_r [1:DEPTH];
  logic             memread_r  [1:DEPTH];
  logic             setflag_r  [1:DEPTH];
  logic [CNT_W-1:0] stall_count_r;

  logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
  logic                     load_use_s;
  logic                     flag_fwd_s;
  logic                     stage1_load_s;

  // Bypass select: scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_sel_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (src_valid[i] && valid_r[k] && regwrite_r[k] &&
            (rd_r[k] == src_addr[i*REG_W +: REG_W]) && (rd_r[k] != ZERO_ADDR)) begin
          fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(k);
        end else begin
          fwd_sel_s[i*SEL_W +: SEL_W] = fwd_sel_s[i*SEL_W +: SEL_W];
        end
      end
    end
  end

  // Load-use hazard: a load in EX cannot bypass to ID this cycle; flush suppresses it.
  always_comb begin
    load_use_s = 1'b0;
    if (issue_valid && !flush && valid_r[1] && memread_r[1] && regwrite_r[1] &&
        (rd_r[1] != ZERO_ADDR)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        load_use_s = load_use_s |
                     (src_valid[i] && (src_addr[i*REG_W +: REG_W] == rd_r[1]));
      end
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Flag forwarding and the stage-1 admit decision.
  always_comb begin
    flag_fwd_s    = issue_valid && issue_flaguse && valid_r[1] && setflag_r[1];
    stage1_load_s = issue_valid && !load_use_s && !flush;
  end

  // Stage shift register and saturating stall counter; stall_ext freezes everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_r[k] <= 1'b0;
      end
      stall_count_r <= '0;
    end else if (!stall_ext) begin
      for (int k = DEPTH; k >= 2; k--) begin
        valid_r[k]    <= valid_r[k-1];
        rd_r[k]       <= rd_r[k-1];
        regwrite_r[k] <= regwrite_r[k-1];
        memread_r[k]  <= memread_r[k-1];
        setflag_r[k]  <= setflag_r[k-1];
      end
      valid_r[1]    <= stage1_load_s;
      rd_r[1]       <= issue_rd;
      regwrite_r[1] <= issue_regwrite;
      memread_r[1]  <= issue_memread;
      setflag_r[1]  <= issue_setflag;
      if (load_use_s && (stall_count_r != {CNT_W{1'b1}})) begin
        stall_count_r <= stall_count_r + CNT_W'(1);
      end else begin
        stall_count_r <= stall_count_r;
      end
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign fwd_sel        = fwd_sel_s;
  assign load_use_stall = load_use_s;
  assign flag_fwd       = flag_fwd_s;
  assign stall_count    = stall_count_r;

endmodule
